// File: rtl/axi_line_master_if.sv
// AXI4 channel structs and the AxiIO bundle carried between the line master and the interconnect.
package axi_pkg;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned PADDR = 32;

    typedef struct packed {
        logic [3:0]       id;
        logic [PADDR-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic             user;
        logic             valid;
    } ax_chan_t;

    typedef struct packed {
        logic ready;
    } ready_t;

    typedef struct packed {
        logic [3:0]      id;
        logic [XLEN-1:0] data;
        logic [1:0]      resp;
        logic            last;
        logic            user;
        logic            valid;
    } r_chan_t;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [XLEN/8-1:0] wstrb;
        logic              last;
        logic              user;
        logic              valid;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       user;
        logic       valid;
    } b_chan_t;
endpackage

interface AxiIO;
    axi_pkg::ax_chan_t mar;
    axi_pkg::ax_chan_t maw;
    axi_pkg::w_chan_t  mw;
    axi_pkg::ready_t   mr;
    axi_pkg::ready_t   mb;
    axi_pkg::ready_t   sar;
    axi_pkg::ready_t   saw;
    axi_pkg::ready_t   sw;
    axi_pkg::r_chan_t  sr;
    axi_pkg::b_chan_t  sb;

    modport master (output mar, maw, mw, mr, mb, input sar, saw, sw, sr, sb);
    modport slave  (input mar, maw, mw, mr, mb, output sar, saw, sw, sr, sb);
endinterface

// File: rtl/axi_line_master.sv
// Cache-line AXI4 master: one line refill or writeback per request as a single INCR burst.
module axi_line_master
    import axi_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 8,
    parameter logic [3:0]  AXI_ID     = 4'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [PADDR-1:0]           req_addr,
    input  logic [LINE_BEATS*XLEN-1:0] req_wdata,
    output logic                       resp_valid,
    output logic                       resp_we,
    output logic [LINE_BEATS*XLEN-1:0] resp_rdata,
    output logic                       resp_err,
    AxiIO.master                       axi
);
    localparam int unsigned      CW        = $clog2(LINE_BEATS);
    localparam int unsigned      OFF       = $clog2(LINE_BEATS * XLEN / 8);
    localparam logic [PADDR-1:0] ADDR_MASK = ~((PADDR'(1) << OFF) - PADDR'(1));
    localparam logic [CW-1:0]    LAST      = CW'(LINE_BEATS - 1);

    typedef enum logic [2:0] {IDLE, AR, RD, AW, WD, WB, RESP} state_t;

    state_t                     state, state_nxt;
    logic [PADDR-1:0]           addr_q;
    logic                       we_q;
    logic                       err_q;
    logic [CW-1:0]              cnt_q;
    logic [LINE_BEATS*XLEN-1:0] line_q;
    int unsigned                beat_lsb;

    assign beat_lsb   = 32'(cnt_q) * XLEN;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_we    = we_q;
    assign resp_err   = err_q;
    assign resp_rdata = line_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // cnt wraps back to 0 only on the final beat, so each burst starts from a clean count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q <= req_addr & ADDR_MASK;
                    we_q   <= req_we;
                    err_q  <= 1'b0;
                    cnt_q  <= '0;
                end
                RD: if (axi.sr.valid) begin
                    cnt_q <= cnt_q + CW'(1);
                    if (axi.sr.resp[1] || (axi.sr.last != (cnt_q == LAST))) err_q <= 1'b1;
                end
                WD: if (axi.sw.ready) cnt_q <= cnt_q + CW'(1);
                WB: if (axi.sb.valid && axi.sb.resp[1]) err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // One buffer serves both directions: holds the write line, then is overwritten by refill beats.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid)   line_q <= req_wdata;
        else if (state == RD && axi.sr.valid) line_q[beat_lsb +: XLEN] <= axi.sr.data;
    end

    always_comb begin
        state_nxt = state;
        axi.mar   = '0;
        axi.maw   = '0;
        axi.mw    = '0;
        axi.mr    = '0;
        axi.mb    = '0;

        axi.mar.id    = AXI_ID;
        axi.mar.addr  = addr_q;
        axi.mar.len   = 8'(LINE_BEATS - 1);
        axi.mar.size  = 3'b011;
        axi.mar.burst = 2'b01;
        axi.maw.id    = AXI_ID;
        axi.maw.addr  = addr_q;
        axi.maw.len   = 8'(LINE_BEATS - 1);
        axi.maw.size  = 3'b011;
        axi.maw.burst = 2'b01;
        axi.mw.data   = line_q[beat_lsb +: XLEN];
        axi.mw.wstrb  = '1;
        axi.mw.last   = (cnt_q == LAST);

        case (state)
            IDLE: if (req_valid) state_nxt = req_we ? AW : AR;
            AR: begin
                axi.mar.valid = 1'b1;
                if (axi.sar.ready) state_nxt = RD;
            end
            RD: begin
                axi.mr.ready = 1'b1;
                if (axi.sr.valid && cnt_q == LAST) state_nxt = RESP;
            end
            AW: begin
                axi.maw.valid = 1'b1;
                if (axi.saw.ready) state_nxt = WD;
            end
            WD: begin
                axi.mw.valid = 1'b1;
                if (axi.sw.ready && cnt_q == LAST) state_nxt = WB;
            end
            WB: begin
                axi.mb.ready = 1'b1;
                if (axi.sb.valid) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{axi.sr.id, axi.sr.user, axi.sr.resp[0],
                           axi.sb.id, axi.sb.user, axi.sb.resp[0]};
endmodule

// File: tb/tb_axi_line_master.sv
// Scoreboard bench for axi_line_master with a directed AXI slave model.
module tb_axi_line_master;
    import axi_pkg::*;

    localparam int unsigned LB = 8;
    localparam int unsigned LW = LB * XLEN;

    typedef struct {
        logic          we;
        logic          err;
        logic [LW-1:0] rdata;
        int            exp_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid, req_ready, req_we;
    logic [PADDR-1:0] req_addr;
    logic [LW-1:0]    req_wdata;
    logic             resp_valid, resp_we, resp_err;
    logic [LW-1:0]    resp_rdata;

    AxiIO axi();

    axi_line_master #(.LINE_BEATS(LB), .AXI_ID(4'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] mkline(input logic [63:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < LB; i++) l[i*64 +: 64] = base + 64'(i);
        return l;
    endfunction

    // Response monitor: every resp_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                chk("resp_unexpected", LW'(1'b1), LW'(1'b0));
            end else begin
                mon_e = sbq.pop_front();
                chk("resp_we", LW'(resp_we), LW'(mon_e.we));
                chk("resp_err", LW'(resp_err), LW'(mon_e.err));
                if (!mon_e.we) chk("resp_rdata", resp_rdata, mon_e.rdata);
                if (mon_e.exp_cyc >= 0) chk("resp_cycle", LW'(cyc), LW'(mon_e.exp_cyc));
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [LW-1:0] wd,
                         input logic exp_err, input logic [LW-1:0] exp_rd, input int lat, input bit push);
        exp_t e;
        int   t;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        chk("req_ready_idle", LW'(req_ready), LW'(1'b1));
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        if (push) begin
            e.we      = we;
            e.err     = exp_err;
            e.rdata   = exp_rd;
            e.exp_cyc = (lat < 0) ? -1 : int'(cyc) + lat;
            sbq.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hdead_beef;
        req_wdata = '1;
        chk("req_ready_busy", LW'(req_ready), LW'(1'b0));
    endtask

    task automatic slave_read(input logic [31:0] exp_addr, input logic [63:0] base, input int ar_wait,
                              input int err_beat, input int early_last, input int abort_after);
        ax_chan_t snap;
        int       t;
        t = 0;
        while (!axi.mar.valid && t < 20) begin @(negedge clk); t++; end
        chk("ar_valid", LW'(axi.mar.valid), LW'(1'b1));
        snap = axi.mar;
        chk("ar_addr", LW'(snap.addr), LW'(exp_addr));
        chk("ar_len_size_burst_id", LW'({snap.len, snap.size, snap.burst, snap.id}),
            LW'({8'd7, 3'd3, 2'd1, 4'h0}));
        chk("ar_zero_fields", LW'({snap.lock, snap.cache, snap.prot, snap.qos, snap.region, snap.user}), '0);
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk);
            chk("ar_stable", LW'(axi.mar), LW'(snap));
        end
        axi.sar.ready = 1'b1;
        @(negedge clk);
        axi.sar.ready = 1'b0;
        for (int b = 0; b < LB; b++) begin
            if (b == abort_after) begin
                axi.sr = '0;
                return;
            end
            axi.sr.valid = 1'b1;
            axi.sr.id    = 4'h5;
            axi.sr.data  = base + 64'(b);
            axi.sr.resp  = (b == err_beat) ? 2'b10 : 2'b00;
            axi.sr.last  = (b == LB - 1) || (b == early_last);
            t = 0;
            while (!axi.mr.ready && t < 20) begin @(negedge clk); t++; end
            chk("r_ready", LW'(axi.mr.ready), LW'(1'b1));
            @(negedge clk);
        end
        axi.sr = '0;
    endtask

    task automatic slave_write(input logic [31:0] exp_addr, input logic [LW-1:0] wd, input int aw_wait,
                               input bit toggle, input logic [1:0] bresp);
        ax_chan_t snap;
        w_chan_t  wsnap;
        int       t;
        int       beat;
        logic     wr, ph, pend;
        t = 0;
        while (!axi.maw.valid && t < 20) begin @(negedge clk); t++; end
        chk("aw_valid", LW'(axi.maw.valid), LW'(1'b1));
        snap = axi.maw;
        chk("aw_addr", LW'(snap.addr), LW'(exp_addr));
        chk("aw_len_size_burst_id", LW'({snap.len, snap.size, snap.burst, snap.id}),
            LW'({8'd7, 3'd3, 2'd1, 4'h0}));
        for (int i = 0; i < aw_wait; i++) begin
            chk("w_before_aw", LW'(axi.mw.valid), LW'(1'b0));
            @(negedge clk);
            chk("aw_stable", LW'(axi.maw), LW'(snap));
        end
        chk("w_before_aw", LW'(axi.mw.valid), LW'(1'b0));
        axi.saw.ready = 1'b1;
        @(negedge clk);
        axi.saw.ready = 1'b0;
        beat = 0; t = 0; ph = 1'b0; pend = 1'b0; wsnap = '0;
        while (beat < LB && t < 100) begin
            if (pend) chk("w_stable", LW'(axi.mw), LW'(wsnap));
            wr = toggle ? ph : 1'b1;
            ph = ~ph;
            axi.sw.ready = wr;
            pend = axi.mw.valid && !wr;
            if (pend) wsnap = axi.mw;
            if (axi.mw.valid && wr) begin
                chk("w_data", LW'(axi.mw.data), LW'(wd[beat*64 +: 64]));
                chk("w_strb", LW'(axi.mw.wstrb), LW'(8'hff));
                chk("w_last", LW'(axi.mw.last), LW'(beat == LB - 1));
                beat++;
            end
            @(negedge clk);
            t++;
        end
        axi.sw.ready = 1'b0;
        chk("w_beats", LW'(beat), LW'(LB));
        axi.sb.valid = 1'b1;
        axi.sb.id    = 4'ha;
        axi.sb.resp  = bresp;
        t = 0;
        while (!axi.mb.ready && t < 20) begin @(negedge clk); t++; end
        chk("b_ready", LW'(axi.mb.ready), LW'(1'b1));
        @(negedge clk);
        axi.sb = '0;
    endtask

    task automatic refill(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [63:0] base,
                          input int ar_wait, input int err_beat, input int early_last,
                          input logic exp_err, input int lat);
        issue(1'b0, addr, '0, exp_err, mkline(base), lat, 1'b1);
        slave_read(exp_addr, base, ar_wait, err_beat, early_last, -1);
    endtask

    task automatic writeback(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [LW-1:0] wd,
                             input int aw_wait, input bit toggle, input logic [1:0] bresp,
                             input logic exp_err, input int lat);
        issue(1'b1, addr, wd, exp_err, '0, lat, 1'b1);
        slave_write(exp_addr, wd, aw_wait, toggle, bresp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        axi.sar   = '0;
        axi.saw   = '0;
        axi.sw    = '0;
        axi.sr    = '0;
        axi.sb    = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", LW'({axi.mar.valid, axi.maw.valid, axi.mw.valid, axi.mr.ready,
                                  axi.mb.ready, resp_valid, resp_err, req_ready}), LW'(8'b0000_0001));
        rst = 1'b1;
        @(negedge clk);

        refill(32'h8000_0047, 32'h8000_0040, 64'h11, 0, -1, -1, 1'b0, 10);
        writeback(32'h8000_1238, 32'h8000_1200, mkline(64'ha0), 3, 1'b1, 2'b00, 1'b0, -1);
        writeback(32'h0000_0fff, 32'h0000_0fc0, mkline(64'h1234_5678_0000_1000), 0, 1'b0, 2'b00, 1'b0, 11);
        refill(32'h0000_2010, 32'h0000_2000, 64'h3000, 0, 3, -1, 1'b1, 10);
        writeback(32'h0000_4040, 32'h0000_4040, mkline(64'h77), 1, 1'b0, 2'b11, 1'b1, -1);
        refill(32'h0000_5000, 32'h0000_5000, 64'h55, 0, -1, -1, 1'b0, 10);
        refill(32'h0000_6008, 32'h0000_6000, 64'h600, 0, -1, 5, 1'b1, 10);
        refill(32'hffff_ffff, 32'hffff_ffc0, 64'h900, 5, -1, -1, 1'b0, 15);

        // reset while the refill is mid-burst
        issue(1'b0, 32'h0000_7000, '0, 1'b0, '0, -1, 1'b0);
        slave_read(32'h0000_7000, 64'hbad0, 0, -1, -1, 3);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", LW'({axi.mar.valid, axi.maw.valid, axi.mw.valid, axi.mr.ready,
                                        axi.mb.ready, resp_valid, resp_err, req_ready}), LW'(8'b0000_0001));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", LW'(req_ready), LW'(1'b1));
        refill(32'h0000_8020, 32'h0000_8000, 64'hc0, 0, -1, -1, 1'b0, 10);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", LW'(sbq.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
